// File: rtl/time_set_ctrl.sv
// time_set_ctrl: time-setting controller for the HH:MM:SS clock core.
// Debounces three active-low buttons, freezes the core while the six BCD digits
// are edited, and commits the edited time back with a one-cycle load strobe.
// Optional feature: define TIME_SET_AUTOREPEAT_EN to enable auto-repeat of the
// increment button while it is held in EDIT.
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int BLINK_CYCLES    = 6000000,
    parameter int REPEAT_CYCLES   = 3000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        b_pause,
    input  logic        b_sel,
    input  logic        b_inc,
    input  logic [23:0] cur_time,
    output logic        pause,
    output logic        load,
    output logic [23:0] load_time,
    output logic [2:0]  sel,
    output logic        blank
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BL_W = $clog2(BLINK_CYCLES + 1);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_EDIT   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    // Button index: 0 = pause, 1 = sel, 2 = inc
    logic [2:0]      raw_s;
    logic [2:0]      sync1_r;
    logic [2:0]      sync2_r;
    logic [2:0]      deb_r;
    logic [2:0]      deb_d_r;
    logic [2:0]      armed_r;
    logic [2:0]      press_r;
    logic [DB_W-1:0] db_cnt_r [3];
    logic [1:0]      warm_cnt_r;
    logic            warm_s;

    logic            pause_p_s;
    logic            sel_p_s;
    logic            inc_p_s;
    logic            inc_evt_s;

    logic [1:0]      state_r;
    logic [1:0]      state_nx_s;
    logic [23:0]     edit_r;
    logic [23:0]     edit_nx_s;
    logic [2:0]      sel_r;
    logic [2:0]      sel_nx_s;
    logic [BL_W-1:0] blink_cnt_r;
    logic [BL_W-1:0] blink_cnt_nx_s;
    logic            phase_r;
    logic            phase_nx_s;
    logic            pause_r;
    logic            load_r;
    logic            blank_r;

    // Step a BCD digit, wrapping to zero once it reaches its maximum
    function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic [3:0] max_v);
        logic [3:0] r;
        if (d >= max_v) begin
            r = 4'd0;
        end else begin
            r = d + 4'd1;
        end
        return r;
    endfunction

    // Increment the digit selected by idx, keeping the hour field legal
    function automatic logic [23:0] inc_digit(input logic [23:0] t, input logic [2:0] idx);
        logic [23:0] r;
        r = t;
        case (idx)
            3'd0: r[3:0]   = bcd_step(t[3:0],   4'd9);
            3'd1: r[7:4]   = bcd_step(t[7:4],   4'd5);
            3'd2: r[11:8]  = bcd_step(t[11:8],  4'd9);
            3'd3: r[15:12] = bcd_step(t[15:12], 4'd5);
            3'd4: r[19:16] = bcd_step(t[19:16], (t[23:20] == 4'd2) ? 4'd3 : 4'd9);
            3'd5: begin
                r[23:20] = bcd_step(t[23:20], 4'd2);
                // Moving into the 20s: an hour digit above 3 would be illegal
                if ((r[23:20] == 4'd2) && (t[19:16] > 4'd3)) begin
                    r[19:16] = 4'd0;
                end else begin
                    r[19:16] = t[19:16];
                end
            end
            default: r = t;
        endcase
        return r;
    endfunction

    assign raw_s  = {b_inc, b_sel, b_pause};
    assign warm_s = (warm_cnt_r == 2'd3);

    // Two-flop synchronizer for the asynchronous buttons (idle = released = 1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 3'b111;
            sync2_r <= 3'b111;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Start-up window so the synchronizer reflects the real pins before arming
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt_r <= 2'd0;
        end else if (!warm_s) begin
            warm_cnt_r <= warm_cnt_r + 2'd1;
        end else begin
            warm_cnt_r <= warm_cnt_r;
        end
    end

    // Debounce: accept a new level after it has differed for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_r <= 3'b111;
            for (int i = 0; i < 3; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] != deb_r[i]) begin
                    if (db_cnt_r[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        deb_r[i]    <= sync2_r[i];
                        db_cnt_r[i] <= '0;
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt_r[i] <= '0;
                end
            end
        end
    end

    // Arm a button only once it has been seen released, so a button held
    // through reset never produces a press; then form one-cycle press pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_r <= 3'b000;
            deb_d_r <= 3'b111;
            press_r <= 3'b000;
        end else begin
            armed_r <= armed_r | ({3{warm_s}} & deb_r & sync2_r);
            deb_d_r <= deb_r;
            press_r <= armed_r & deb_d_r & ~deb_r;
        end
    end

    assign pause_p_s = press_r[0];
    assign sel_p_s   = press_r[1] & ~press_r[0];
    assign inc_p_s   = press_r[2] & ~press_r[1] & ~press_r[0];

`ifdef TIME_SET_AUTOREPEAT_EN
    localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
    logic [RP_W-1:0] rep_cnt_r;
    logic            rep_hold_s;
    logic            rep_evt_s;

    assign rep_hold_s = (state_r == ST_EDIT) && !deb_r[2] && armed_r[2] && !press_r[1];
    assign rep_evt_s  = rep_hold_s && (rep_cnt_r == RP_W'(REPEAT_CYCLES - 1));
    assign inc_evt_s  = inc_p_s | (rep_evt_s & ~press_r[1] & ~press_r[0]);

    // Auto-repeat interval counter while the increment button is held in EDIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_r <= '0;
        end else if (!rep_hold_s || rep_evt_s) begin
            rep_cnt_r <= '0;
        end else begin
            rep_cnt_r <= rep_cnt_r + RP_W'(1);
        end
    end
`else
    assign inc_evt_s = inc_p_s;
`endif

    // Next-state, edit-register and digit-select logic
    always_comb begin
        state_nx_s = state_r;
        edit_nx_s  = edit_r;
        sel_nx_s   = sel_r;
        case (state_r)
            ST_RUN: begin
                if (pause_p_s) begin
                    state_nx_s = ST_EDIT;
                    edit_nx_s  = cur_time;
                    sel_nx_s   = 3'd0;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_EDIT: begin
                if (pause_p_s) begin
                    state_nx_s = ST_COMMIT;
                end else if (sel_p_s) begin
                    sel_nx_s = (sel_r >= 3'd5) ? 3'd0 : sel_r + 3'd1;
                end else if (inc_evt_s) begin
                    edit_nx_s = inc_digit(edit_r, sel_r);
                end else begin
                    state_nx_s = ST_EDIT;
                end
            end
            ST_COMMIT: state_nx_s = ST_RUN;
            default:   state_nx_s = ST_RUN;
        endcase
    end

    // Blink timing: restart visible on EDIT entry and on every edit action
    always_comb begin
        blink_cnt_nx_s = blink_cnt_r;
        phase_nx_s     = phase_r;
        if (((state_r != ST_EDIT) && (state_nx_s == ST_EDIT)) ||
            ((state_r == ST_EDIT) && (sel_p_s || inc_evt_s))) begin
            blink_cnt_nx_s = '0;
            phase_nx_s     = 1'b0;
        end else if (blink_cnt_r == BL_W'(BLINK_CYCLES - 1)) begin
            blink_cnt_nx_s = '0;
            phase_nx_s     = ~phase_r;
        end else begin
            blink_cnt_nx_s = blink_cnt_r + BL_W'(1);
        end
    end

    // State, edit registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_RUN;
            edit_r      <= 24'd0;
            sel_r       <= 3'd0;
            blink_cnt_r <= '0;
            phase_r     <= 1'b0;
            pause_r     <= 1'b0;
            load_r      <= 1'b0;
            blank_r     <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            edit_r      <= edit_nx_s;
            sel_r       <= sel_nx_s;
            blink_cnt_r <= blink_cnt_nx_s;
            phase_r     <= phase_nx_s;
            pause_r     <= (state_nx_s != ST_RUN);
            load_r      <= (state_nx_s == ST_COMMIT);
            blank_r     <= (state_nx_s == ST_EDIT) && phase_nx_s;
        end
    end

    assign pause     = pause_r;
    assign load      = load_r;
    assign load_time = edit_r;
    assign sel       = sel_r;
    assign blank     = blank_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Testbench for time_set_ctrl: directed vector table for digit editing plus
// hand-written sequences for debounce, commit, priority, blink and reset cases.
module tb_time_set_ctrl;

    logic        clk;
    logic        rst_n;
    logic        b_pause;
    logic        b_sel;
    logic        b_inc;
    logic [23:0] cur_time;
    logic        pause;
    logic        load;
    logic [23:0] load_time;
    logic [2:0]  sel;
    logic        blank;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          op;        // 0 = sel press, 1 = inc press
        logic [23:0] exp_time;
        logic [2:0]  exp_sel;
    } vec_t;

    vec_t vecs [22];

    time_set_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .BLINK_CYCLES(8),
        .REPEAT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .b_pause(b_pause),
        .b_sel(b_sel),
        .b_inc(b_inc),
        .cur_time(cur_time),
        .pause(pause),
        .load(load),
        .load_time(load_time),
        .sel(sel),
        .blank(blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hold a button low for hold cycles, release it and let it settle
    task automatic press(input int which, input int hold);
        case (which)
            0: b_pause = 1'b0;
            1: b_sel   = 1'b0;
            default: b_inc = 1'b0;
        endcase
        repeat (hold) @(posedge clk);
        #1;
        b_pause = 1'b1;
        b_sel   = 1'b1;
        b_inc   = 1'b1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    // Press pause (optionally inc together) and verify a single clean commit
    task automatic commit_check(input string name, input logic [23:0] exp, input logic with_inc);
        int   seen;
        logic [23:0] val;
        logic p_at;
        logic p_after;
        logic l_after;
        seen    = 0;
        val     = 24'd0;
        p_at    = 1'b0;
        p_after = 1'b1;
        l_after = 1'b1;
        b_pause = 1'b0;
        if (with_inc) b_inc = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (load) begin
                seen++;
                val  = load_time;
                p_at = pause;
                @(negedge clk);
                p_after = pause;
                l_after = load;
            end
        end
        b_pause = 1'b1;
        b_inc   = 1'b1;
        check({name, "_load_count"}, seen, 1);
        check({name, "_load_time"}, val, exp);
        check({name, "_pause_at_load"}, p_at, 1'b1);
        check({name, "_pause_after"}, p_after, 1'b0);
        check({name, "_load_after"}, l_after, 1'b0);
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] rep_exp;
        int k;

        vecs[0]  = '{0, 24'h195959, 3'd1};
        vecs[1]  = '{1, 24'h195909, 3'd1};
        vecs[2]  = '{0, 24'h195909, 3'd2};
        vecs[3]  = '{1, 24'h195009, 3'd2};
        vecs[4]  = '{0, 24'h195009, 3'd3};
        vecs[5]  = '{1, 24'h190009, 3'd3};
        vecs[6]  = '{0, 24'h190009, 3'd4};
        vecs[7]  = '{1, 24'h100009, 3'd4};
        vecs[8]  = '{0, 24'h100009, 3'd5};
        vecs[9]  = '{1, 24'h200009, 3'd5};
        vecs[10] = '{0, 24'h200009, 3'd0};
        vecs[11] = '{1, 24'h200000, 3'd0};
        vecs[12] = '{0, 24'h200000, 3'd1};
        vecs[13] = '{0, 24'h200000, 3'd2};
        vecs[14] = '{0, 24'h200000, 3'd3};
        vecs[15] = '{0, 24'h200000, 3'd4};
        vecs[16] = '{1, 24'h210000, 3'd4};
        vecs[17] = '{1, 24'h220000, 3'd4};
        vecs[18] = '{1, 24'h230000, 3'd4};
        vecs[19] = '{1, 24'h200000, 3'd4};
        vecs[20] = '{0, 24'h200000, 3'd5};
        vecs[21] = '{1, 24'h000000, 3'd5};

        rst_n    = 1'b0;
        b_pause  = 1'b1;
        b_sel    = 1'b1;
        b_inc    = 1'b1;
        cur_time = 24'h000000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pause", pause, 1'b0);
        check("rst_load", load, 1'b0);
        check("rst_load_time", load_time, 24'h0);
        check("rst_sel", sel, 3'd0);
        check("rst_blank", blank, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Enter and commit with 23:59:59
        cur_time = 24'h235959;
        press(0, 10);
        check("enter_pause", pause, 1'b1);
        check("enter_sel", sel, 3'd0);
        check("enter_load_time", load_time, 24'h235959);
        commit_check("commit1", 24'h235959, 1'b0);

        // Table-driven digit editing from 19:59:59
        cur_time = 24'h195959;
        press(0, 10);
        check("tbl_enter", load_time, 24'h195959);
        for (int i = 0; i < 22; i++) begin
            press((vecs[i].op == 0) ? 1 : 2, 10);
            check($sformatf("vec%0d_time", i), load_time, vecs[i].exp_time);
            check($sformatf("vec%0d_sel", i), sel, vecs[i].exp_sel);
        end
        commit_check("commit_tbl", 24'h000000, 1'b0);

        // Hour clamp: h2 becoming 2 clears h1 when it exceeds 3
        cur_time = 24'h175959;
        press(0, 10);
        for (int i = 0; i < 5; i++) press(1, 10);
        check("clamp_sel", sel, 3'd5);
        press(2, 10);
        check("clamp_time", load_time, 24'h205959);
        commit_check("commit_clamp", 24'h205959, 1'b0);

        // Bounce rejection then a single clean increment
        cur_time = 24'h000000;
        press(0, 10);
        press(2, 3);
        check("bounce_short", load_time, 24'h000000);
        press(2, 10);
        check("bounce_long", load_time, 24'h000001);

        // Pause and inc in the same cycle: commit wins, digits unchanged
        commit_check("prio", 24'h000001, 1'b1);

        // Auto-repeat (or a single increment when not compiled in)
        cur_time = 24'h000000;
        press(0, 10);
`ifdef TIME_SET_AUTOREPEAT_EN
        rep_exp = 4'd3;
`else
        rep_exp = 4'd1;
`endif
        press(2, 46);
        check("repeat_s1", {28'd0, load_time[3:0]}, {28'd0, rep_exp});
        commit_check("commit_rep", {20'd0, rep_exp}, 1'b0);
        check("run_blank", blank, 1'b0);

        // Blink: 8 visible cycles then 8 blanked cycles after EDIT entry
        b_pause = 1'b0;
        @(negedge clk);
        k = 0;
        while (!pause && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("blink_entry", pause, 1'b1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("blink%0d", i), blank, (i < 8) ? 1'b0 : 1'b1);
            @(negedge clk);
        end
        b_pause = 1'b1;

        // Reset mid-EDIT: outputs return to reset values at once
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_pause", pause, 1'b0);
        check("midrst_load", load, 1'b0);
        check("midrst_load_time", load_time, 24'h0);
        check("midrst_sel", sel, 3'd0);
        check("midrst_blank", blank, 1'b0);

        // Button held through reset gives no press until re-pressed
        b_pause = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("held_no_press", pause, 1'b0);
        b_pause = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("held_still_run", pause, 1'b0);
        cur_time = 24'h123456;
        press(0, 10);
        check("repress_pause", pause, 1'b1);
        commit_check("commit_final", 24'h123456, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
